hazard_fwd_unit: RTL

Parametrised forwarding and hazard unit for the 5-stage pipelined CPU.
- Combinational part: EX-stage operand forwarding selects with MEM-over-WB priority, and load-use stall detection.
- Sequential part: a scoreboard FSM for a multi-cycle multiply/divide unit (MDU). It holds off ID-stage instructions that read or overwrite the MDU's pending destination register, or that try to issue a second MDU op, until the result has been written to the register file.
- Placement: between the ID/EX, EX/MEM and MEM/WB pipeline registers and the PC/IF-ID write-enable logic.

---
 rtl/hazard_fwd_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// Forwarding, load-use and MDU scoreboard hazard unit for the 5-stage pipeline.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / mdu_stall_cycles counters.
module hazard_fwd_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_mdu,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              mdu_start,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       mdu_stall_cycles,
`endif
    output logic              mdu_busy,
    output logic              mdu_done
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [REG_AW-1:0] pend_rd;
    logic [CNT_W-1:0]  cnt;

    logic lu;
    logic md;
    logic haz_pend;
    logic haz_ex;

    // EX operand forwarding: the younger MEM result wins over WB
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            fwd_a = 2'd2;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            fwd_a = 2'd1;
        end
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rt)) begin
            fwd_b = 2'd2;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rt)) begin
            fwd_b = 2'd1;
        end
    end

    // Load-use and MDU scoreboard stall terms
    always_comb begin
        lu = ex_memread && (ex_rd != '0) &&
             ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));

        haz_pend = (id_rs_used && (id_rs == pend_rd)) ||
                   (id_rt_used && (id_rt == pend_rd)) ||
                   (id_regwrite && (id_rd == pend_rd));

        haz_ex   = (id_rs_used && (id_rs == ex_rd)) ||
                   (id_rt_used && (id_rt == ex_rd)) ||
                   (id_regwrite && (id_rd == ex_rd));

        md = 1'b0;
        if ((state != S_IDLE) && (pend_rd != '0) && haz_pend) begin
            md = 1'b1;
        end
        if ((state == S_IDLE) && mdu_start && (ex_rd != '0) && haz_ex) begin
            md = 1'b1;
        end
        // Only one MDU op may be in flight
        if (id_is_mdu && ((state != S_IDLE) || mdu_start)) begin
            md = 1'b1;
        end

        stall = lu || md;
    end

    // Scoreboard FSM; a start while already busy is dropped without effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pend_rd <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mdu_start) begin
                        state   <= S_BUSY;
                        pend_rd <= ex_rd;
                        cnt     <= CNT_W'(MDU_LAT - 1);
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mdu_busy = (state != S_IDLE);
    assign mdu_done = (state == S_DONE);

`ifdef HAZARD_PERF_EN
    // Saturating stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles     <= '0;
            mdu_stall_cycles <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (md && (mdu_stall_cycles != '1)) begin
                mdu_stall_cycles <= mdu_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
